// File: rtl/branch_pkg.sv
// Shared types and constants for the branch controller: opcodes, target LUT, default stack depth.
package branch_pkg;

    typedef enum logic [2:0] {
        OpNone = 3'd0,
        OpJmp  = 3'd1,
        OpBeq  = 3'd2,
        OpBne  = 3'd3,
        OpBlt  = 3'd4,
        OpCall = 3'd5,
        OpRet  = 3'd6
    } br_op_t;

    localparam int unsigned DefaultDepth = 4;
    localparam int unsigned LutSize      = 16;

    // Read-only branch-target table, entry i holds 16*i.
    localparam int unsigned BrLut [LutSize] = '{
        0, 16, 32, 48, 64, 80, 96, 112, 128, 144, 160, 176, 192, 208, 224, 240
    };

endpackage

// File: rtl/branch_ctrl_if.sv
// Bundle between the PC/ALU stages (master) and the branch controller (slave).
interface branch_ctrl_if
    import branch_pkg::*;
#(
    parameter int unsigned D     = 8,
    parameter int unsigned DEPTH = DefaultDepth
) ();

    br_op_t                 br_op;
    logic [3:0]             lut_idx;
    logic [D-1:0]           prog_ctr;
    logic                   flag_we;
    logic                   alu_zero;
    logic                   alu_neg;
    logic                   branch;
    logic [D-1:0]           target;
    logic [$clog2(DEPTH):0] stack_depth;
    logic                   err;

    modport master (
        output br_op, lut_idx, prog_ctr, flag_we, alu_zero, alu_neg,
        input  branch, target, stack_depth, err
    );

    modport slave (
        input  br_op, lut_idx, prog_ctr, flag_we, alu_zero, alu_neg,
        output branch, target, stack_depth, err
    );

endinterface

// File: rtl/ret_stack.sv
// LIFO return-address stack; push/pop are ignored when full/empty respectively.
module ret_stack #(
    parameter int unsigned D     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [D-1:0]           data_i,
    output logic [D-1:0]           top_o,
    output logic [$clog2(DEPTH):0] depth_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] DepthOne = (AW + 1)'(1);
    localparam logic [AW:0] DepthMax = (AW + 1)'(DEPTH);

    logic [D-1:0] mem_q [DEPTH];
    logic [AW:0]  depth_q, depth_d, top_ptr;
    logic         do_push, do_pop;

    assign full_o  = (depth_q == DepthMax);
    assign empty_o = (depth_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign top_ptr = depth_q - DepthOne;
    assign top_o   = mem_q[top_ptr[AW-1:0]];
    assign depth_o = depth_q;

    always_comb begin
        depth_d = depth_q;
        if (do_push) begin
            depth_d = depth_q + DepthOne;
        end else if (do_pop) begin
            depth_d = depth_q - DepthOne;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // Contents are left stale on reset; depth alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem_q[depth_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch decision unit: combinational branch/target from opcode, LUT, latched flags and
// return stack; sticky err flags stack overflow/underflow.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned D     = 8,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input logic          clk,
    input logic          reset,
    branch_ctrl_if.slave bus
);

    logic                   z_q, n_q, err_q, err_d;
    logic                   branch, push, pop, full, empty;
    logic [D-1:0]           target, lut_tgt, top, ret_addr;
    logic [$clog2(DEPTH):0] depth;

    assign lut_tgt  = D'(BrLut[bus.lut_idx]);
    assign ret_addr = bus.prog_ctr + D'(1);

    always_comb begin
        branch = 1'b0;
        target = '0;
        push   = 1'b0;
        pop    = 1'b0;
        err_d  = err_q;
        if (!reset) begin
            case (bus.br_op)
                OpJmp: begin
                    branch = 1'b1;
                    target = lut_tgt;
                end
                OpBeq: begin
                    branch = z_q;
                    target = lut_tgt;
                end
                OpBne: begin
                    branch = ~z_q;
                    target = lut_tgt;
                end
                OpBlt: begin
                    branch = n_q;
                    target = lut_tgt;
                end
                OpCall: begin
                    if (!full) begin
                        branch = 1'b1;
                        target = lut_tgt;
                        push   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OpRet: begin
                    if (!empty) begin
                        branch = 1'b1;
                        target = top;
                        pop    = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            z_q   <= 1'b0;
            n_q   <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (bus.flag_we) begin
                z_q <= bus.alu_zero;
                n_q <= bus.alu_neg;
            end
            err_q <= err_d;
        end
    end

    ret_stack #(
        .D     (D),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (ret_addr),
        .top_o   (top),
        .depth_o (depth),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.branch      = branch;
    assign bus.target      = target;
    assign bus.stack_depth = depth;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed plus random stimulus against a queue-based reference model of the branch controller.
module tb_branch_ctrl;
    import branch_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    bit   m_z, m_n, m_err;
    int   rs[$];

    branch_ctrl_if #(.D(8), .DEPTH(4)) bus ();

    branch_ctrl #(.D(8), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_state(input string tag);
        logic [2:0] exp_d;
        exp_d = 3'(rs.size());
        checks++;
        assert (bus.stack_depth === exp_d) else begin
            errors++;
            $error("FAIL %s depth obs=%0d exp=%0d", tag, bus.stack_depth, exp_d);
        end
        checks++;
        assert (bus.err === m_err) else begin
            errors++;
            $error("FAIL %s err obs=%0b exp=%0b", tag, bus.err, m_err);
        end
    endtask

    task automatic step(input int op, input int idx, input int pc, input bit fwe,
                        input bit az, input bit an, input bit rst, input string tag);
        bit         eb;
        logic [7:0] et;
        logic [2:0] op3;
        op3          = op[2:0];
        bus.br_op    = br_op_t'(op3);
        bus.lut_idx  = idx[3:0];
        bus.prog_ctr = pc[7:0];
        bus.flag_we  = fwe;
        bus.alu_zero = az;
        bus.alu_neg  = an;
        reset        = rst;
        eb = 1'b0;
        et = 8'h00;
        case (op)
            1: begin eb = 1'b1;  et = 8'(16 * idx); end
            2: begin eb = m_z;   et = 8'(16 * idx); end
            3: begin eb = !m_z;  et = 8'(16 * idx); end
            4: begin eb = m_n;   et = 8'(16 * idx); end
            5: if (rs.size() < 4) begin eb = 1'b1; et = 8'(16 * idx); end
            6: if (rs.size() > 0) begin eb = 1'b1; et = 8'(rs[$]); end
            default: ;
        endcase
        if (rst) begin
            eb = 1'b0;
            et = 8'h00;
        end
        #1;
        checks++;
        assert (bus.branch === eb) else begin
            errors++;
            $error("FAIL %s branch obs=%0b exp=%0b", tag, bus.branch, eb);
        end
        checks++;
        assert (bus.target === et) else begin
            errors++;
            $error("FAIL %s target obs=%0h exp=%0h", tag, bus.target, et);
        end
        check_state(tag);
        @(posedge clk);
        if (rst) begin
            m_z = 1'b0;
            m_n = 1'b0;
            m_err = 1'b0;
            rs.delete();
        end else begin
            if (op == 5) begin
                if (rs.size() < 4) rs.push_back((pc + 1) % 256);
                else m_err = 1'b1;
            end
            if (op == 6) begin
                if (rs.size() > 0) void'(rs.pop_back());
                else m_err = 1'b1;
            end
            if (fwe) begin
                m_z = az;
                m_n = an;
            end
        end
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        bus.br_op    = OpJmp;
        bus.lut_idx  = 4'd3;
        bus.prog_ctr = 8'h00;
        bus.flag_we  = 1'b0;
        bus.alu_zero = 1'b0;
        bus.alu_neg  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_z = 1'b0; m_n = 1'b0; m_err = 1'b0;
        rs.delete();
        check_state("reset");
        step(1, 3, 0, 0, 0, 0, 1, "jmp_in_reset");

        step(1, 3, 0, 0, 0, 0, 0, "jmp3");
        step(2, 5, 0, 1, 1, 0, 0, "beq_flag_cycle");
        step(2, 5, 0, 0, 0, 0, 0, "beq_taken");
        step(3, 5, 0, 0, 0, 0, 0, "bne_not_taken");
        step(4, 9, 0, 1, 0, 1, 0, "blt_flag_cycle");
        step(4, 9, 0, 0, 0, 0, 0, "blt_taken");
        step(7, 4, 0, 0, 0, 0, 0, "undef_op");

        step(5, 2, 8'h07, 0, 0, 0, 0, "call_07");
        step(0, 0, 0, 0, 0, 0, 0, "none_after_call");
        step(6, 0, 0, 0, 0, 0, 0, "ret_08");

        for (int i = 0; i < 5; i++) step(5, i + 1, 16 + i, 0, 0, 0, 0, "call_fill");
        for (int i = 0; i < 4; i++) step(6, 0, 0, 0, 0, 0, 0, "ret_lifo");
        step(1, 1, 0, 0, 0, 0, 1, "reset_a");

        step(6, 0, 0, 0, 0, 0, 0, "ret_empty");
        step(1, 1, 0, 0, 0, 0, 0, "jmp_after_err");
        step(0, 0, 0, 0, 0, 0, 1, "reset_b");

        step(5, 6, 8'hFF, 0, 0, 0, 0, "call_ff");
        step(6, 0, 0, 0, 0, 0, 0, "ret_wrap");
        step(5, 1, 8'h20, 0, 0, 0, 0, "call_a");
        step(5, 2, 8'h30, 0, 0, 0, 0, "call_b");
        step(6, 0, 0, 0, 0, 0, 1, "reset_mid_call");
        step(6, 0, 0, 0, 0, 0, 0, "ret_after_reset");

        for (int i = 0; i < 400; i++) begin
            step(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 39) == 0), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter D, default 8, program-counter / target width in bits.
REQ-002 Parameter DEPTH, default 4, return-stack entries (power of 2, ≥2).
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 br_op  input  3  branch opcode, type br_op_t: NONE, JMP, BEQ, BNE, BLT, CALL, RET.
REQ-006 lut_idx  input  4  index into the 16-entry branch-target LUT.
REQ-007 prog_ctr  input  D  current instruction address from the PC stage.
REQ-008 flag_we  input  1  capture ALU flags this cycle.
REQ-009 alu_zero  input  1  ALU zero result.
REQ-010 alu_neg  input  1  ALU negative result.
REQ-011 branch  output  1  PC loads target next edge when high.
REQ-012 target  output  D  absolute jump address.
REQ-013 stack_depth  output  $clog2(DEPTH)+1  occupied return-stack entries.
REQ-014 err  output  1  sticky fault: stack overflow or underflow.

Function
REQ-015 branch and target SHALL be combinational from br_op, lut_idx, registered flags, and stack top; zero-latency into the PC.
REQ-016 Flag registers z_q, n_q SHALL load alu_zero, alu_neg on posedge when flag_we=1; otherwise hold.
REQ-017 Branch conditions SHALL use z_q/n_q (pre-edge values); a flag_we in the same cycle affects only later instructions.
REQ-018 JMP: branch=1, target=LUT[lut_idx].
REQ-019 BEQ: branch=z_q; BNE: branch=!z_q; BLT: branch=n_q; target=LUT[lut_idx] for all three, including when not taken.
REQ-020 CALL with stack not full: branch=1, target=LUT[lut_idx]; push (prog_ctr+1) mod 2^D at the edge.
REQ-021 RET with stack not empty: branch=1, target=top entry; pop at the edge.
REQ-022 NONE: branch=0, target=0; stack and err unchanged.
REQ-023 CALL when stack_depth==DEPTH: branch=0, target=0, no push, err set to 1 at the edge.
REQ-024 RET when stack_depth==0: branch=0, target=0, no pop, err set to 1 at the edge.
REQ-025 err SHALL stay 1 until reset; it SHALL NOT block later branches.
REQ-026 Return address SHALL wrap: prog_ctr=2^D-1 pushes 0.
REQ-027 Undefined br_op encodings SHALL behave as NONE.
REQ-028 Stack is LIFO; stack_depth increments on push and decrements on pop, never exceeding DEPTH or going below 0.

Reset
REQ-029 While reset=1: branch=0, target=0 regardless of br_op, and no push or pop.
REQ-030 At a reset edge: z_q=0, n_q=0, stack_depth=0, err=0; stack contents need not be cleared.
REQ-031 Reset asserted mid-call-sequence SHALL discard all pending return addresses.

Structure
REQ-032 Package branch_pkg SHALL hold br_op_t, the 16-entry LUT constant (default LUT[i]=16*i), and DEPTH default.
REQ-033 The return stack SHALL be a sub-module ret_stack (push, pop, top, depth, full, empty).
REQ-034 The LUT SHALL be a read-only constant with no write port.

Verification
REQ-035 JMP lut_idx=3 -> branch=1, target=0x30 in the same cycle.
REQ-036 flag_we=1, alu_zero=1 then BEQ lut_idx=5 next cycle -> branch=1, target=0x50; BEQ in the flag_we cycle with z_q=0 -> branch=0.
REQ-037 CALL at prog_ctr=0x07, lut_idx=2 -> target=0x20, depth=1; RET later -> branch=1, target=0x08, depth=0.
REQ-038 Five consecutive CALLs (DEPTH=4) -> fifth has branch=0, err=1, depth=4; four RETs return addresses in LIFO order.
REQ-039 RET with empty stack -> branch=0, err=1; subsequent JMP lut_idx=1 -> branch=1, target=0x10, err stays 1.
REQ-040 CALL at prog_ctr=0xFF then RET -> target=0x00; reset after two CALLs -> depth=0, err=0, RET -> err=1.
